// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time byte-stream loader into instruction memory
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned IMEM_DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES   = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int unsigned        IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]        DEPTH     = 32'(IMEM_DEPTH_WORDS);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    localparam state_t S_TAIL = S_CSUM;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t             state_q, state_d;
    logic               hdr_seen_q, hdr_seen_d;
    logic [15:0]        n_q, n_d;
    logic [15:0]        idx_q, idx_d;
    logic [1:0]         lane_q, lane_d;
    logic [23:0]        word_q, word_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic        accept;
    logic        counting;
    logic [15:0] n_full;

    always_comb begin
        in_ready = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                   || (state_q == S_CSUM)
`endif
                   ;
    end

    assign accept   = in_valid && in_ready;
    // The idle timer is armed only once the first header byte has arrived.
    assign counting = in_ready && ((state_q != S_LEN) || hdr_seen_q);
    assign n_full   = {in_data, n_q[7:0]};

    always_comb begin
        state_d    = state_q;
        hdr_seen_d = hdr_seen_q;
        n_d        = n_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        word_d     = word_q;
        idle_d     = idle_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        if (accept) csum_d = csum_q ^ in_data;
`endif
        if (accept)        idle_d = '0;
        else if (counting) idle_d = idle_q + 1'b1;

        case (state_q)
            S_LEN: begin
                if (accept) begin
                    if (!hdr_seen_q) begin
                        hdr_seen_d = 1'b1;
                        n_d        = {8'h00, in_data};
                    end else begin
                        n_d = n_full;
                        if (n_full == 16'd0)               state_d = S_TAIL;
                        else if ({16'd0, n_full} > DEPTH)  state_d = S_ERR;
                        else                               state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: word_d[7:0]   = in_data;
                        2'd1: word_d[15:8]  = in_data;
                        2'd2: word_d[23:16] = in_data;
                        default: begin
                            we_d    = 1'b1;
                            addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                            wdata_d = {in_data, word_q};
                            idx_d   = idx_q + 16'd1;
                            if (idx_q == n_q - 16'd1) state_d = S_TAIL;
                        end
                    endcase
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: ;
        endcase

        // An accepted byte on the same cycle always beats the timeout.
        if (!accept && counting && (idle_q == IDLE_LAST)) state_d = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LEN;
            hdr_seen_q <= 1'b0;
            n_q        <= '0;
            idx_q      <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            idle_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_seen_q <= hdr_seen_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            idle_q     <= idle_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign cpu_reset  = (state_q != S_DONE);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          TO    = 16;

    typedef logic [31:0] word_q_t[$];
    typedef logic [7:0]  byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, imem_we, cpu_reset, done, error;
    logic [31:0] imem_addr, imem_wdata;

    always #5 clk = ~clk;

    program_loader #(
        .IMEM_DEPTH_WORDS(DEPTH),
        .BASE_ADDR(BASE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    always @(negedge clk) begin
        if (imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, imem_addr, BASE);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        check_reset_vals("rst_hold");
        reset = 1'b0;
        step();
        check_reset_vals("rst_after");
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    // Reference stream: LE 16-bit count, LE words, optional XOR checksum.
    task automatic build_stream(input word_q_t words, output byte_q_t s);
        logic [15:0] n16;
        logic [7:0]  x;
        s = {};
        n16 = 16'(words.size());
        s.push_back(n16[7:0]);
        s.push_back(n16[15:8]);
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) s.push_back(8'((words[i] >> (8 * k)) & 32'hFF));
        end
        x = 8'h00;
        foreach (s[i]) x = x ^ s[i];
`ifdef LOADER_CHECKSUM_EN
        s.push_back(x);
`endif
    endtask

    task automatic run_image(input word_q_t words, input int lo_gap, input int hi_gap,
                             input bit with_reset);
        byte_q_t s;
        build_stream(words, s);
        if (with_reset) do_reset();
        for (int i = 0; i < s.size() - 1; i++)
            send_byte(s[i], int'($urandom_range(hi_gap, lo_gap)));
        check("pre_done", 32'(done), 32'd0);
        check("pre_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(s[s.size() - 1], int'($urandom_range(hi_gap, lo_gap)));
        check("done", 32'(done), 32'd1);
        check("done_cpu_reset", 32'(cpu_reset), 32'd0);
        check("done_ready", 32'(in_ready), 32'd0);
        check("done_error", 32'(error), 32'd0);
        check("last_we", 32'(imem_we), 32'(words.size() > 0));
        send_byte(8'hAA, 0);
        step();
        check("done_sticky", 32'(done), 32'd1);
        check("n_writes", 32'(got_addr.size()), 32'(words.size()));
        if (got_addr.size() == words.size()) begin
            foreach (words[i]) begin
                check("wr_addr", got_addr[i], BASE + 32'(4 * i));
                check("wr_data", got_data[i], words[i]);
            end
        end
    endtask

    initial begin
        word_q_t w;
        int cnt;

        do_reset();

        // Loader waits indefinitely before the first header byte.
        repeat (3 * TO) step();
        check("prestart_error", 32'(error), 32'd0);
        check("prestart_ready", 32'(in_ready), 32'd1);

        w = {32'h0050_0093, 32'h00A0_0113};
        run_image(w, 0, 0, 1'b1);

        w = {};
        run_image(w, 0, 2, 1'b1);

        for (int it = 0; it < 6; it++) begin
            w = {};
            for (int j = 0; j < int'($urandom_range(8, 1)); j++) w.push_back($urandom);
            run_image(w, 0, 3, 1'b1);
        end

        // Largest legal image.
        w = {};
        for (int j = 0; j < DEPTH; j++) w.push_back($urandom);
        run_image(w, 0, 0, 1'b1);

        // Gaps of TO-1 idle cycles: each byte lands just as the timer would fire.
        w = {32'h1234_5678};
        run_image(w, TO - 1, TO - 1, 1'b1);

        // Oversized header.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_done", 32'(done), 32'd0);
        check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        check("ovf_ready", 32'(in_ready), 32'd0);
        for (int j = 0; j < 4; j++) send_byte(8'(j), 0);
        step();
        check("ovf_writes", 32'(got_addr.size()), 32'd0);

        // Stream stalls after two payload bytes.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 1);
        cnt = 0;
        while (!error && cnt < 10 * TO) begin
            step();
            cnt++;
        end
        check("timeout_cycles", 32'(cnt), 32'(TO));
        check("timeout_ready", 32'(in_ready), 32'd0);
        check("timeout_cpu_reset", 32'(cpu_reset), 32'd1);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        step();
        check("timeout_error_sticky", 32'(error), 32'd1);
        check("timeout_writes", 32'(got_addr.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        begin
            byte_q_t bad;
            bad = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
            foreach (bad[i]) send_byte(bad[i], 0);
        end
        check("csum_error", 32'(error), 32'd1);
        check("csum_done", 32'(done), 32'd0);
        check("csum_cpu_reset", 32'(cpu_reset), 32'd1);
        step();
        check("csum_writes", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() == 1) begin
            check("csum_wr_addr", got_addr[0], BASE);
            check("csum_wr_data", got_data[0], 32'hDEAD_BEEF);
        end
`endif

        // Reset mid-load after one of two words has been written.
        do_reset();
        begin
            byte_q_t part;
            part = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
            foreach (part[i]) send_byte(part[i], 0);
        end
        check("mid_writes", 32'(got_addr.size()), 32'd1);
        reset = 1'b1;
        step();
        check_reset_vals("mid_rst");
        reset = 1'b0;
        step();
        check_reset_vals("mid_rst_after");
        got_addr.delete();
        got_data.delete();
        w = {$urandom};
        run_image(w, 0, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
